// File: rtl/cnt191_seq.sv
// Command sequencer for a 74LS191-style 4-bit up/down counter: drives D/NLD/NCT/NUD,
// mirrors the expected count in a shadow register and flags any disagreement with Q_FB.
module cnt191_seq #(
    parameter int W     = 4,
    parameter int CYC_W = 4
) (
    input  logic             CP,
    input  logic             CLR,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [W-1:0]     PRESET,
    input  logic [W-1:0]     LIMIT,
    input  logic [CYC_W-1:0] CYCLES,
    input  logic [W-1:0]     Q_FB,
    output logic [W-1:0]     D,
    output logic             NLD,
    output logic             NCT,
    output logic             NUD,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [1:0] M_LOAD   = 2'b00;
    localparam logic [1:0] M_UP     = 2'b01;
    localparam logic [1:0] M_DN     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_UP,
        S_RUN_DN,
        S_FINISH
    } state_t;

    state_t           state, state_n;
    logic [1:0]       mode_r, mode_n;
    logic [W-1:0]     preset_r, preset_n;
    logic [W-1:0]     limit_r, limit_n;
    logic [CYC_W-1:0] cycles_r, cycles_n;
    logic [W-1:0]     shadow, shadow_n;
    logic [CYC_W-1:0] cyc_cnt, cyc_n;
    logic [W-1:0]     d_n;
    logic             nld_n, nct_n, nud_n, busy_n, done_n, err_n;

    logic [W-1:0]     sh_inc, sh_dec, dn_target;
    logic [CYC_W:0]   cyc_inc, cyc_goal;

    assign sh_inc    = shadow + W'(1);
    assign sh_dec    = shadow - W'(1);
    // Down leg ends at LIMIT for a plain count-down, back at PRESET when bouncing.
    assign dn_target = (mode_r == M_DN) ? limit_r : preset_r;
    assign cyc_inc   = {1'b0, cyc_cnt} + (CYC_W + 1)'(1);
    assign cyc_goal  = (cycles_r == '0) ? (CYC_W + 1)'(1) : {1'b0, cycles_r};

    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            state    <= S_IDLE;
            mode_r   <= '0;
            preset_r <= '0;
            limit_r  <= '0;
            cycles_r <= '0;
            shadow   <= '0;
            cyc_cnt  <= '0;
            D        <= '0;
            NLD      <= 1'b1;
            NCT      <= 1'b1;
            NUD      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_n;
            mode_r   <= mode_n;
            preset_r <= preset_n;
            limit_r  <= limit_n;
            cycles_r <= cycles_n;
            shadow   <= shadow_n;
            cyc_cnt  <= cyc_n;
            D        <= d_n;
            NLD      <= nld_n;
            NCT      <= nct_n;
            NUD      <= nud_n;
            BUSY     <= busy_n;
            DONE     <= done_n;
            ERR      <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_r;
        preset_n = preset_r;
        limit_n  = limit_r;
        cycles_n = cycles_r;
        shadow_n = shadow;
        cyc_n    = cyc_cnt;
        d_n      = D;
        nld_n    = NLD;
        nct_n    = NCT;
        nud_n    = NUD;
        busy_n   = BUSY;
        done_n   = 1'b0;
        err_n    = ERR;

        unique case (state)
            S_IDLE: begin
                if (START) begin
                    mode_n   = MODE;
                    preset_n = PRESET;
                    limit_n  = LIMIT;
                    cycles_n = CYCLES;
                    shadow_n = PRESET;
                    cyc_n    = '0;
                    d_n      = PRESET;
                    nld_n    = 1'b0;
                    nct_n    = 1'b1;
                    busy_n   = 1'b1;
                    err_n    = 1'b0;
                    state_n  = S_LOAD;
                end
            end

            S_LOAD: begin
                nld_n = 1'b1;
                if (mode_r == M_LOAD || preset_r == limit_r) begin
                    done_n  = 1'b1;
                    state_n = S_FINISH;
                end else if (mode_r == M_DN) begin
                    nct_n   = 1'b0;
                    nud_n   = 1'b1;
                    state_n = S_RUN_DN;
                end else begin
                    nct_n   = 1'b0;
                    nud_n   = 1'b0;
                    state_n = S_RUN_UP;
                end
            end

            S_RUN_UP: begin
                if (Q_FB != shadow) begin
                    err_n   = 1'b1;
                    nct_n   = 1'b1;
                    nld_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    shadow_n = sh_inc;
                    if (sh_inc == limit_r) begin
                        if (mode_r == M_UP) begin
                            nct_n   = 1'b1;
                            done_n  = 1'b1;
                            state_n = S_FINISH;
                        end else begin
                            // Bounce turnaround: keep counting, just flip direction.
                            nud_n   = 1'b1;
                            state_n = S_RUN_DN;
                        end
                    end
                end
            end

            S_RUN_DN: begin
                if (Q_FB != shadow) begin
                    err_n   = 1'b1;
                    nct_n   = 1'b1;
                    nld_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    shadow_n = sh_dec;
                    if (sh_dec == dn_target) begin
                        if (mode_r == M_DN) begin
                            nct_n   = 1'b1;
                            done_n  = 1'b1;
                            state_n = S_FINISH;
                        end else begin
                            cyc_n = cyc_inc[CYC_W-1:0];
                            if (cyc_inc == cyc_goal) begin
                                nct_n   = 1'b1;
                                done_n  = 1'b1;
                                state_n = S_FINISH;
                            end else begin
                                nud_n   = 1'b0;
                                state_n = S_RUN_UP;
                            end
                        end
                    end
                end
            end

            S_FINISH: begin
                nct_n   = 1'b1;
                nld_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cnt191_seq.sv
// Bench for cnt191_seq: ideal 74LS191 model on the feedback path, per-cycle expected
// control traces queued at command issue and popped on every falling edge.
module tb_cnt191_seq;

    logic       CP = 1'b0;
    logic       CLR = 1'b1;
    logic       START = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [3:0] PRESET = 4'd0;
    logic [3:0] LIMIT = 4'd0;
    logic [3:0] CYCLES = 4'd0;
    logic [3:0] Q_FB;
    logic [3:0] D;
    logic       NLD, NCT, NUD, BUSY, DONE, ERR;

    int n_tests = 0;
    int n_fail  = 0;

    cnt191_seq #(.W(4), .CYC_W(4)) dut (
        .CP(CP), .CLR(CLR), .START(START), .MODE(MODE), .PRESET(PRESET),
        .LIMIT(LIMIT), .CYCLES(CYCLES), .Q_FB(Q_FB), .D(D), .NLD(NLD),
        .NCT(NCT), .NUD(NUD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CP = ~CP;

    // Ideal counter: asynchronous load while NLD=0, count on rising edge while NCT=0.
    logic [3:0] cnt = 4'd0;
    logic       fault = 1'b0;
    always @(posedge CP) begin
        if (!NLD)      cnt <= D;
        else if (!NCT) cnt <= NUD ? cnt - 4'd1 : cnt + 4'd1;
    end
    assign Q_FB = fault ? 4'd3 : (!NLD ? D : cnt);

    typedef struct {
        logic       nld, nct, nud, busy, done, err;
        logic [3:0] d, q;
        bit         chk_nud, chk_q;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] preset, limit, cycles;
        int         inj;     // 0 none, 1 START mid-run, 2 START in the DONE cycle
        logic [3:0] final_q;
    } vec_t;

    exp_t sb[$];

    function automatic exp_t mk(logic nld, logic nct, logic nud, logic busy, logic done,
                                logic err, logic [3:0] d, logic [3:0] q, bit cn, bit cq);
        exp_t e;
        e.nld = nld; e.nct = nct; e.nud = nud; e.busy = busy; e.done = done;
        e.err = err; e.d = d; e.q = q; e.chk_nud = cn; e.chk_q = cq;
        return e;
    endfunction

    task automatic check(string name, exp_t e);
        bit ok;
        ok = (NLD === e.nld) && (NCT === e.nct) && (BUSY === e.busy) &&
             (DONE === e.done) && (ERR === e.err) && (D === e.d) &&
             (!e.chk_nud || NUD === e.nud) && (!e.chk_q || Q_FB === e.q);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @%0t: got nld=%b nct=%b nud=%b busy=%b done=%b err=%b d=%0d q=%0d; want nld=%b nct=%b nud=%b(chk %0d) busy=%b done=%b err=%b d=%0d q=%0d(chk %0d)",
                     name, $time, NLD, NCT, NUD, BUSY, DONE, ERR, D, Q_FB,
                     e.nld, e.nct, e.nud, e.chk_nud, e.busy, e.done, e.err, e.d, e.q, e.chk_q);
        end
    endtask

    // Expected trace from the counter's point of view: load, one cycle per step, done, idle.
    task automatic push_trace(logic [1:0] mode, logic [3:0] p, logic [3:0] l, logic [3:0] c);
        logic [3:0] q;
        int k, reps;
        q = p;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, p, p, 1'b0, 1'b1));
        if (mode != 2'b00 && p != l) begin
            if (mode == 2'b10) begin
                k = int'(4'(p - l));
                repeat (k) begin sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, p, q, 1'b1, 1'b1)); q = q - 4'd1; end
            end else begin
                k = int'(4'(l - p));
                reps = (mode == 2'b01) ? 1 : ((c == 4'd0) ? 1 : int'(c));
                repeat (reps) begin
                    repeat (k) begin sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p, q, 1'b1, 1'b1)); q = q + 4'd1; end
                    if (mode == 2'b11)
                        repeat (k) begin sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, p, q, 1'b1, 1'b1)); q = q - 4'd1; end
                end
            end
        end
        sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, p, q, 1'b0, 1'b1));
        sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, p, q, 1'b0, 1'b1));
    endtask

    // Called at a falling edge; drives START and walks the queued trace one cycle at a time.
    task automatic run_cmd(vec_t v, int id);
        exp_t e;
        int idx, inj_idx;
        MODE = v.mode; PRESET = v.preset; LIMIT = v.limit; CYCLES = v.cycles;
        START = 1'b1;
        push_trace(v.mode, v.preset, v.limit, v.cycles);
        inj_idx = (v.inj == 1) ? 2 : (v.inj == 2) ? sb.size() - 2 : -1;
        idx = 0;
        while (sb.size() > 0) begin
            @(negedge CP);
            e = sb.pop_front();
            check($sformatf("vec%0d_cyc%0d", id, idx), e);
            START = (idx == inj_idx);
            if (idx == inj_idx) begin
                MODE = ~v.mode; PRESET = ~v.preset; LIMIT = v.preset; CYCLES = 4'd7;
            end
            idx++;
        end
        START = 1'b0;
        n_tests++;
        if (Q_FB !== v.final_q) begin
            n_fail++;
            $display("FAIL vec%0d_final_q: got %0d want %0d", id, Q_FB, v.final_q);
        end
    endtask

    vec_t vecs[8];
    exp_t rst_e, idle_e;

    initial begin
        vecs[0] = '{2'b01, 4'd3,  4'd6,  4'd0, 1, 4'd6};
        vecs[1] = '{2'b10, 4'd2,  4'd14, 4'd0, 0, 4'd14};
        vecs[2] = '{2'b11, 4'd5,  4'd7,  4'd2, 2, 4'd5};
        vecs[3] = '{2'b00, 4'd9,  4'd9,  4'd0, 2, 4'd9};
        vecs[4] = '{2'b01, 4'd4,  4'd4,  4'd0, 0, 4'd4};
        vecs[5] = '{2'b01, 4'd14, 4'd1,  4'd0, 1, 4'd1};
        vecs[6] = '{2'b11, 4'd0,  4'd15, 4'd0, 0, 4'd0};
        vecs[7] = '{2'b11, 4'd10, 4'd8,  4'd1, 0, 4'd10};
        rst_e = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

        @(negedge CP);
        check("reset_state", rst_e);
        CLR = 1'b0;

        for (int i = 0; i < 8; i++) run_cmd(vecs[i], i);

        // Stuck feedback: mismatch detected on the second run edge, ERR sticks until next START.
        fault = 1'b1;
        MODE = 2'b01; PRESET = 4'd3; LIMIT = 4'd6; CYCLES = 4'd0; START = 1'b1;
        @(negedge CP); START = 1'b0;
        check("flt_load", mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0));
        @(negedge CP);
        check("flt_run1", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0));
        @(negedge CP);
        check("flt_run2", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0));
        @(negedge CP);
        check("flt_err_done", mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0));
        idle_e = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CP);
            check($sformatf("flt_idle%0d", i), idle_e);
        end
        fault = 1'b0;
        run_cmd('{2'b00, 4'd9, 4'd2, 4'd0, 0, 4'd9}, 100);

        // Asynchronous abort in the middle of an up count.
        MODE = 2'b01; PRESET = 4'd3; LIMIT = 4'd6; START = 1'b1;
        @(negedge CP); START = 1'b0;
        @(negedge CP);
        @(negedge CP);
        check("clr_pre", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 1'b1, 1'b1));
        CLR = 1'b1;
        #1;
        check("clr_async", rst_e);
        @(negedge CP);
        check("clr_held", rst_e);
        CLR = 1'b0;
        run_cmd('{2'b01, 4'd3, 4'd6, 4'd0, 0, 4'd6}, 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
